// File: rtl/dcpu_pkg.sv
// Shared types and defaults for the dcpu16 interrupt path.
package dcpu_pkg;
    localparam int MSG_W         = 16;
    localparam int DEPTH_DEFAULT = 256;

    typedef enum logic [1:0] {
        SRC_NONE,
        SRC_SW,
        SRC_HW
    } src_t;
endpackage

// File: rtl/int_fifo.sv
// Synchronous message FIFO clocked on the core's falling edge.
// The head is read combinationally from rd_ptr; the storage array has no reset.
module int_fifo #(
    parameter int DEPTH = 256,
    parameter int W     = 16,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int CNT_W = PTR_W + 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             wr_en,
    input  logic [W-1:0]     wr_data,
    input  logic             rd_en,
    output logic             full,
    output logic             empty,
    output logic [CNT_W-1:0] count,
    output logic [W-1:0]     head
);
    logic [W-1:0]     mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             do_rd;
    logic             do_wr;

    assign full  = (count == CNT_W'(DEPTH));
    assign empty = (count == '0);
    assign do_rd = rd_en && !empty;
    // A full queue still accepts a write when the head leaves in the same cycle.
    assign do_wr = wr_en && (!full || do_rd);
    assign head  = mem[rd_ptr];

    always_ff @(negedge clk) begin
        if (do_wr) mem[wr_ptr] <= wr_data;
    end

    always_ff @(negedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_wr) wr_ptr <= wr_ptr + PTR_W'(1);
            if (do_rd) rd_ptr <= rd_ptr + PTR_W'(1);
            if (do_wr && !do_rd)      count <= count + CNT_W'(1);
            else if (do_rd && !do_wr) count <= count - CNT_W'(1);
        end
    end
endmodule

// File: rtl/interrupt_queue.sv
// dcpu16 interrupt queue: arbitrates SW INT and hardware requests into a FIFO,
// applying IA==0 discard, IAQ delivery hold-off and sticky overflow.
module interrupt_queue #(
    parameter int DEPTH = dcpu_pkg::DEPTH_DEFAULT,
    parameter int NSRC  = 4,
    parameter int MSG_W = dcpu_pkg::MSG_W
) (
    input  logic                     CORE_CLK,
    input  logic                     RESET_N,
    input  logic [NSRC-1:0]          HW_req,
    input  logic [NSRC*MSG_W-1:0]    HW_msg,
    output logic [NSRC-1:0]          HW_ack,
    input  logic                     SW_req,
    input  logic [MSG_W-1:0]         SW_msg,
    output logic                     SW_ack,
    input  logic                     IA_zero,
    input  logic                     IAQ_en,
    output logic                     INT_valid,
    output logic [MSG_W-1:0]         INT_msg,
    input  logic                     INT_take,
    output logic [$clog2(DEPTH):0]   COUNT,
    output logic                     ON_FIRE
);
    import dcpu_pkg::*;

    localparam int IDX_W = (NSRC > 1) ? $clog2(NSRC) : 1;

    src_t             sel;
    logic [IDX_W-1:0] sel_idx;
    logic [MSG_W-1:0] sel_msg;
    logic [NSRC-1:0]  hw_win;
    logic             sw_done;
    logic [NSRC-1:0]  hw_done;
    logic             pend;
    logic [MSG_W-1:0] pend_msg;
    logic             fifo_full;
    logic             fifo_empty;
    logic             pop;
    logic             wr_en;
    logic [MSG_W-1:0] head;

    // Descending scan so the lowest eligible index is the last one assigned.
    always_comb begin
        sel     = SRC_NONE;
        sel_idx = '0;
        sel_msg = '0;
        if (SW_req && !sw_done) begin
            sel     = SRC_SW;
            sel_msg = SW_msg;
        end else begin
            for (int k = NSRC - 1; k >= 0; k--) begin
                if (HW_req[k] && !hw_done[k]) begin
                    sel     = SRC_HW;
                    sel_idx = IDX_W'(k);
                    sel_msg = HW_msg[k*MSG_W +: MSG_W];
                end
            end
        end
    end

    always_comb begin
        hw_win = '0;
        if (sel == SRC_HW) hw_win[sel_idx] = 1'b1;
    end

    assign pop   = INT_take && INT_valid;
    assign wr_en = pend && !IA_zero;

    // done flags keep a held request from being taken twice; they clear once req drops.
    always_ff @(negedge CORE_CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            SW_ack   <= 1'b0;
            HW_ack   <= '0;
            sw_done  <= 1'b0;
            hw_done  <= '0;
            pend     <= 1'b0;
            pend_msg <= '0;
            ON_FIRE  <= 1'b0;
        end else begin
            SW_ack   <= (sel == SRC_SW);
            HW_ack   <= hw_win;
            sw_done  <= SW_req && (sw_done || (sel == SRC_SW));
            hw_done  <= HW_req & (hw_done | hw_win);
            pend     <= (sel != SRC_NONE);
            pend_msg <= sel_msg;
            if (pend && !IA_zero && fifo_full && !pop) ON_FIRE <= 1'b1;
        end
    end

    int_fifo #(
        .DEPTH (DEPTH),
        .W     (MSG_W)
    ) u_fifo (
        .clk     (CORE_CLK),
        .rst_n   (RESET_N),
        .wr_en   (wr_en),
        .wr_data (pend_msg),
        .rd_en   (pop),
        .full    (fifo_full),
        .empty   (fifo_empty),
        .count   (COUNT),
        .head    (head)
    );

    assign INT_valid = !fifo_empty && !IAQ_en;
    assign INT_msg   = fifo_empty ? '0 : head;
endmodule

// File: tb/tb_interrupt_queue.sv
// Self-checking bench for interrupt_queue: directed scenarios plus random traffic,
// compared against a queue-based reference model.
module tb_interrupt_queue;
    localparam int DEPTH = 256;
    localparam int NSRC  = 4;
    localparam int W     = 16;
    localparam int CW    = $clog2(DEPTH) + 1;

    logic             clk      = 1'b0;
    logic             rst_n    = 1'b0;
    logic [NSRC-1:0]  hw_req   = '0;
    logic [NSRC*W-1:0] hw_msg  = '0;
    logic             sw_req   = 1'b0;
    logic [W-1:0]     sw_msg   = '0;
    logic             ia_zero  = 1'b0;
    logic             iaq_en   = 1'b0;
    logic             int_take = 1'b0;
    logic [NSRC-1:0]  hw_ack;
    logic             sw_ack;
    logic             int_valid;
    logic [W-1:0]     int_msg;
    logic [CW-1:0]    count;
    logic             on_fire;

    int checks = 0;
    int errors = 0;

    interrupt_queue #(.DEPTH(DEPTH), .NSRC(NSRC), .MSG_W(W)) dut (
        .CORE_CLK  (clk),
        .RESET_N   (rst_n),
        .HW_req    (hw_req),
        .HW_msg    (hw_msg),
        .HW_ack    (hw_ack),
        .SW_req    (sw_req),
        .SW_msg    (sw_msg),
        .SW_ack    (sw_ack),
        .IA_zero   (ia_zero),
        .IAQ_en    (iaq_en),
        .INT_valid (int_valid),
        .INT_msg   (int_msg),
        .INT_take  (int_take),
        .COUNT     (count),
        .ON_FIRE   (on_fire)
    );

    always #5 clk = ~clk;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h t=%0t", nm, act, exp, $time);
        end
    endtask

    // Reference model: a plain queue of pending messages plus the sticky flag.
    logic [W-1:0]    mq[$];
    logic [NSRC:0]   exp_ack[$];
    bit              m_fire, m_pend, m_pop, m_full, sw_blk;
    bit [NSRC-1:0]   hw_blk;
    logic [W-1:0]    m_pend_msg;
    int              m_w;

    always @(negedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mq.delete();
            exp_ack.delete();
            m_fire = 0;
            m_pend = 0;
            sw_blk = 0;
            hw_blk = '0;
        end else begin
            m_pop  = int_take && (mq.size() != 0) && !iaq_en;
            m_full = (mq.size() == DEPTH);
            if (m_pop) void'(mq.pop_front());
            if (m_pend && !ia_zero) begin
                if (!m_full || m_pop) mq.push_back(m_pend_msg);
                else m_fire = 1;
            end
            m_pend = 0;
            m_w = -1;
            if (sw_req && !sw_blk) m_w = NSRC;
            else for (int k = 0; k < NSRC; k++)
                if (m_w < 0 && hw_req[k] && !hw_blk[k]) m_w = k;
            sw_blk = sw_req && (sw_blk || m_w == NSRC);
            for (int k = 0; k < NSRC; k++) hw_blk[k] = hw_req[k] && (hw_blk[k] || m_w == k);
            if (m_w >= 0) begin
                m_pend = 1;
                m_pend_msg = (m_w == NSRC) ? sw_msg : hw_msg[m_w*W +: W];
                exp_ack.push_back((m_w == NSRC) ? (NSRC+1)'(1) : (NSRC+1)'(2 << m_w));
            end
        end
    end

    // Monitor: compares DUT outputs with the model on the non-active edge.
    always @(posedge clk) begin
        if (rst_n) begin
            check("count", 32'(count), 32'(mq.size()));
            check("on_fire", 32'(on_fire), 32'(m_fire));
            check("int_valid", 32'(int_valid), 32'((mq.size() != 0) && !iaq_en));
            if (int_valid && mq.size() != 0) check("int_msg", 32'(int_msg), 32'(mq[0]));
            if ({hw_ack, sw_ack} != '0 || exp_ack.size() != 0) begin
                if (exp_ack.size() == 0) check("ack_unexpected", 32'({hw_ack, sw_ack}), 32'd0);
                else check("ack", 32'({hw_ack, sw_ack}), 32'(exp_ack.pop_front()));
            end
        end
    end

    task automatic step(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
            if (sw_ack) sw_req = 1'b0;
            for (int k = 0; k < NSRC; k++) if (hw_ack[k]) hw_req[k] = 1'b0;
        end
    endtask

    task automatic sw_send(input logic [W-1:0] m);
        sw_req = 1'b1;
        sw_msg = m;
        step(2);
    endtask

    task automatic hw_send(input int k, input logic [W-1:0] m);
        hw_req[k] = 1'b1;
        hw_msg[k*W +: W] = m;
        step(2);
    endtask

    task automatic drain(input int n);
        int_take = 1'b1;
        step(n);
        int_take = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired t=%0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        step(3);
        rst_n = 1'b1;
        check("rst_count", 32'(count), 32'd0);
        check("rst_fire", 32'(on_fire), 32'd0);
        check("rst_valid", 32'(int_valid), 32'd0);
        step(1);

        // basic order
        sw_send(16'h1234);
        hw_send(2, 16'h00AB);
        check("basic_count", 32'(count), 32'd2);
        check("basic_head0", 32'(int_msg), 32'h1234);
        drain(1);
        check("basic_head1", 32'(int_msg), 32'h00AB);
        check("basic_count1", 32'(count), 32'd1);
        drain(3);

        // priority
        sw_req = 1'b1; sw_msg = 16'h00A1;
        hw_req[0] = 1'b1; hw_msg[0*W +: W] = 16'h00B0;
        hw_req[3] = 1'b1; hw_msg[3*W +: W] = 16'h00C3;
        step(5);
        check("prio_count", 32'(count), 32'd3);
        check("prio_head0", 32'(int_msg), 32'h00A1);
        drain(1);
        check("prio_head1", 32'(int_msg), 32'h00B0);
        drain(1);
        check("prio_head2", 32'(int_msg), 32'h00C3);
        drain(2);

        // IA==0 discard
        ia_zero = 1'b1;
        hw_send(1, 16'h5555);
        step(1);
        check("ia_count", 32'(count), 32'd0);
        check("ia_valid", 32'(int_valid), 32'd0);
        ia_zero = 1'b0;

        // IAQ hold-off
        iaq_en = 1'b1;
        sw_send(16'h0011);
        sw_send(16'h0022);
        sw_send(16'h0033);
        check("iaq_valid", 32'(int_valid), 32'd0);
        check("iaq_count", 32'(count), 32'd3);
        iaq_en = 1'b0;
        #1;
        check("iaq_release", 32'(int_valid), 32'd1);
        check("iaq_head", 32'(int_msg), 32'h0011);
        drain(4);

        // overflow, then full queue with simultaneous enqueue and take
        for (int i = 0; i < DEPTH; i++) sw_send(W'(i));
        check("full_count", 32'(count), 32'd256);
        check("full_fire0", 32'(on_fire), 32'd0);
        sw_send(16'hDEAD);
        step(1);
        check("ovf_fire", 32'(on_fire), 32'd1);
        check("ovf_count", 32'(count), 32'd256);
        check("ovf_head", 32'(int_msg), 32'h0000);
        sw_req = 1'b1; sw_msg = 16'hBEEF;
        step(1);
        int_take = 1'b1;
        step(1);
        int_take = 1'b0;
        check("wrap_count", 32'(count), 32'd256);
        check("wrap_fire", 32'(on_fire), 32'd1);
        check("wrap_head", 32'(int_msg), 32'h0001);
        drain(DEPTH - 1);
        check("wrap_tail", 32'(int_msg), 32'hBEEF);
        check("wrap_tail_count", 32'(count), 32'd1);
        drain(2);

        // reset mid-operation
        for (int i = 0; i < 5; i++) sw_send(W'(16'h0100 + i));
        check("pre_rst_count", 32'(count), 32'd5);
        check("pre_rst_fire", 32'(on_fire), 32'd1);
        sw_req = 1'b1; sw_msg = 16'h0777;
        step(1);
        #2 rst_n = 1'b0;
        #1;
        check("midrst_count", 32'(count), 32'd0);
        check("midrst_fire", 32'(on_fire), 32'd0);
        check("midrst_valid", 32'(int_valid), 32'd0);
        check("midrst_acks", 32'({hw_ack, sw_ack}), 32'd0);
        sw_req = 1'b0;
        step(2);
        rst_n = 1'b1;
        step(2);

        // random traffic
        for (int c = 0; c < 400; c++) begin
            ia_zero  = ($urandom_range(0, 7) == 0);
            iaq_en   = ($urandom_range(0, 3) == 0);
            int_take = 1'($urandom_range(0, 1));
            if (!sw_req && !sw_ack && $urandom_range(0, 3) == 0) begin
                sw_req = 1'b1;
                sw_msg = W'($urandom);
            end
            for (int k = 0; k < NSRC; k++) begin
                if (!hw_req[k] && !hw_ack[k] && $urandom_range(0, 3) == 0) begin
                    hw_req[k] = 1'b1;
                    hw_msg[k*W +: W] = W'($urandom);
                end
            end
            step(1);
        end
        sw_req  = 1'b0;
        hw_req  = '0;
        ia_zero = 1'b0;
        iaq_en  = 1'b0;
        drain(DEPTH + 4);
        check("final_count", 32'(count), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
